sc_io_input: RTL and testbench

Board-input front end for the single-cycle computer: the reader-side counterpart of the hex-display output ports. Samples four active-low push keys and ten slide switches, synchronizes and debounces them, and keeps per-key toggle bits. Presents two 5-bit operands as zero-extended 32-bit words on the data-memory input ports (`in_port0`, `in_port1`), mirrors them on the LEDs, and raises a sticky change flag the CPU side acknowledges.

---
 rtl/sc_io_input.sv | 100 ++++++++++
 tb/tb_sc_io_input.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_io_input.sv
// Board-input front end: synchronizes and debounces push keys, keeps per-key
// toggle bits and presents two 5-bit operands to the CPU data-memory ports and LEDs.
module sc_io_input #(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 20
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [3:0]  key,
   input  logic [9:0]  sw,
   input  logic        in_ack,
   output logic [31:0] in_port0,
   output logic [31:0] in_port1,
   output logic [9:0]  led,
   output logic [3:0]  key_event,
   output logic        in_valid
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic [3:0]       key_sync1;
   logic [3:0]       key_sync2;
   logic [9:0]       sw_sync1;
   logic [9:0]       sw_s;
   logic [3:0]       stable;
   logic [3:0]       tog;
   logic [CNT_W-1:0] cnt [4];
   logic [4:0]       op_a;
   logic [4:0]       op_b;
   logic             chg;
   logic             unused_sw;

   // keys idle high (released), switches idle low
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         key_sync1 <= 4'hF;
         key_sync2 <= 4'hF;
         sw_sync1  <= '0;
         sw_s      <= '0;
      end else begin
         key_sync1 <= key;
         key_sync2 <= key_sync1;
         sw_sync1  <= sw;
         sw_s      <= sw_sync1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         stable    <= 4'hF;
         tog       <= '0;
         key_event <= '0;
         for (int k = 0; k < 4; k++) begin
            cnt[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            key_event[k] <= 1'b0;
            if (key_sync2[k] == stable[k]) begin
               cnt[k] <= '0;
            end else if (cnt[k] == CNT_MAX) begin
               stable[k] <= key_sync2[k];
               cnt[k]    <= '0;
               // only the press (falling) edge counts; release is silent
               if (!key_sync2[k]) begin
                  key_event[k] <= 1'b1;
                  tog[k]       <= ~tog[k];
               end
            end else begin
               cnt[k] <= cnt[k] + 1'b1;
            end
         end
      end
   end

   assign op_a      = {sw_s[4:2], tog[1:0]};
   assign op_b      = {sw_s[9:7], tog[3:2]};
   assign chg       = ({op_b, op_a} != led);
   assign unused_sw = ^{sw_s[1:0], sw_s[6:5]};

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         in_port0 <= '0;
         in_port1 <= '0;
         led      <= '0;
         in_valid <= 1'b0;
      end else begin
         in_port0 <= {27'b0, op_a};
         in_port1 <= {27'b0, op_b};
         led      <= {op_b, op_a};
         // a fresh change beats a simultaneous acknowledge
         if (chg) begin
            in_valid <= 1'b1;
         end else if (in_ack) begin
            in_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sc_io_input.sv
// Scoreboard bench for sc_io_input: a behavioural model predicts every output
// change; a monitor pops and compares each change the design presents.
module tb_sc_io_input;

   localparam int DB = 4;

   logic        clock  = 1'b0;
   logic        resetn = 1'b1;
   logic [3:0]  key    = 4'hF;
   logic [9:0]  sw     = '0;
   logic        in_ack = 1'b0;
   logic [31:0] in_port0;
   logic [31:0] in_port1;
   logic [9:0]  led;
   logic [3:0]  key_event;
   logic        in_valid;

   sc_io_input #(.DB_CYCLES(DB), .CNT_W(20)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .key       (key),
      .sw        (sw),
      .in_ack    (in_ack),
      .in_port0  (in_port0),
      .in_port1  (in_port1),
      .led       (led),
      .key_event (key_event),
      .in_valid  (in_valid)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   typedef struct packed {
      int unsigned c;
      logic [3:0]  ev;
      logic [9:0]  led;
      logic        vld;
   } txn_t;

   txn_t        exp_q[$];
   logic [14:0] last_push = '0;

   function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endfunction

   // reference model: raw inputs reach the debouncer two edges late; a key
   // level is accepted once DB consecutive samples since the last accepted
   // change all disagree with the current level
   logic [3:0]    m_k1, m_k2, m_stable, m_tog, m_ev;
   logic [9:0]    m_s1, m_s2, m_led;
   logic          m_vld;
   logic [DB-1:0] m_win [4];
   int            m_since [4];

   task automatic model_reset();
      m_k1 = 4'hF; m_k2 = 4'hF; m_stable = 4'hF;
      m_tog = '0; m_ev = '0; m_s1 = '0; m_s2 = '0; m_led = '0; m_vld = 1'b0;
      for (int k = 0; k < 4; k++) begin
         m_win[k]   = '0;
         m_since[k] = 0;
      end
   endtask

   task automatic model_step();
      logic [9:0] nxt;
      nxt = {m_s2[9:7], m_tog[3:2], m_s2[4:2], m_tog[1:0]};
      if (nxt != m_led) m_vld = 1'b1;
      else if (in_ack)  m_vld = 1'b0;
      m_led = nxt;
      m_ev  = '0;
      for (int k = 0; k < 4; k++) begin
         m_win[k]   = {m_win[k][DB-2:0], m_k2[k]};
         m_since[k] = m_since[k] + 1;
         if (m_since[k] >= DB && m_win[k] == {DB{~m_stable[k]}}) begin
            m_stable[k] = ~m_stable[k];
            m_since[k]  = 0;
            if (!m_stable[k]) begin
               m_ev[k]  = 1'b1;
               m_tog[k] = ~m_tog[k];
            end
         end
      end
      m_k2 = m_k1; m_k1 = key;
      m_s2 = m_s1; m_s1 = sw;
   endtask

   initial model_reset();

   always @(posedge clock) begin
      logic [14:0] cur_exp;
      cyc++;
      if (!resetn) model_reset();
      else         model_step();
      cur_exp = {m_ev, m_led, m_vld};
      if (cur_exp != last_push) begin
         exp_q.push_back('{c: cyc, ev: m_ev, led: m_led, vld: m_vld});
         last_push = cur_exp;
      end
   end

   logic [78:0] prev = '0;

   always @(posedge clock) begin
      logic [78:0] cur;
      txn_t        t;
      #1;
      cur = {key_event, led, in_valid, in_port0, in_port1};
      if (cur !== prev) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_output: got %0h with no change predicted (cycle %0d)", cur, cyc);
         end else begin
            t = exp_q.pop_front();
            check("scoreboard", {32'(cyc), cur},
                  {t.c, t.ev, t.led, t.vld, 27'b0, t.led[4:0], 27'b0, t.led[9:5]});
         end
         prev = cur;
      end
   end

   task automatic wait_cycles(int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic ack_pulse();
      in_ack = 1'b1;
      wait_cycles(1);
      in_ack = 1'b0;
   endtask

   initial begin
      int idx;
      int hold;
      int waited;

      #1 resetn = 1'b0;
      wait_cycles(3);
      resetn = 1'b1;
      wait_cycles(8);
      check("idle_after_reset", {key_event, in_valid, led}, '0);

      // clean press of key0
      key[0] = 1'b0;
      wait_cycles(8);
      check("key0_port0", in_port0, 32'h1);
      check("key0_led", led, 10'h001);
      check("key0_valid", in_valid, 1'b1);
      key[0] = 1'b1;
      wait_cycles(8);
      ack_pulse();
      wait_cycles(2);
      check("ack_clears", in_valid, 1'b0);

      // bounce on key1, then a real press
      key[1] = 1'b0; wait_cycles(3);
      key[1] = 1'b1; wait_cycles(1);
      key[1] = 1'b0; wait_cycles(3);
      key[1] = 1'b1; wait_cycles(8);
      check("bounce_rejected", in_port0, 32'h1);
      key[1] = 1'b0; wait_cycles(8);
      check("key1_accepted", in_port0, 32'h3);
      key[1] = 1'b1; wait_cycles(8);

      // asynchronous reset mid-cycle
      @(negedge clock);
      #2 resetn = 1'b0;
      #1 check("async_reset", {in_port0, in_port1, led, key_event, in_valid}, '0);
      wait_cycles(2);
      resetn = 1'b1;
      wait_cycles(10);

      // switches
      sw = 10'b1110011100;
      wait_cycles(4);
      check("sw_port0", in_port0, 32'h1C);
      check("sw_port1", in_port1, 32'h1C);
      check("sw_led", led, 10'h39C);
      ack_pulse();
      wait_cycles(2);
      sw = sw ^ 10'b0001100011;
      wait_cycles(4);
      check("unused_sw_led", led, 10'h39C);
      check("unused_sw_valid", in_valid, 1'b0);

      // ack colliding with a key-driven change
      sw = '0;
      wait_cycles(4);
      check("pre_collision_valid", in_valid, 1'b1);
      key[0] = 1'b0;
      wait_cycles(6);
      ack_pulse();
      check("collision_led", led, 10'h001);
      check("collision_valid", in_valid, 1'b1);
      key[0] = 1'b1;
      wait_cycles(8);
      ack_pulse();
      wait_cycles(2);
      check("lone_ack", in_valid, 1'b0);

      // key2 twice, then key2+key3 together
      for (int p = 0; p < 2; p++) begin
         key[2] = 1'b0; wait_cycles(8);
         key[2] = 1'b1; wait_cycles(8);
         check("key2_toggle", in_port1, (p == 0) ? 32'h1 : 32'h0);
      end
      key[3:2] = 2'b00;
      waited = 0;
      while (key_event == 4'b0000 && waited < 12) begin
         wait_cycles(1);
         waited++;
      end
      check("dual_event", key_event, 4'b1100);
      wait_cycles(8);
      check("dual_port1", in_port1, 32'h3);
      key = 4'hF;
      wait_cycles(8);

      // randomized phase
      for (int i = 0; i < 400; i++) begin
         idx = $urandom_range(3, 0);
         key[idx] = ~key[idx];
         if ($urandom_range(7, 0) == 0) sw = 10'($urandom);
         hold = $urandom_range(8, 1);
         for (int j = 0; j < hold; j++) begin
            in_ack = ($urandom_range(5, 0) == 0);
            wait_cycles(1);
         end
         if ($urandom_range(99, 0) == 0) begin
            resetn = 1'b0;
            wait_cycles(2);
            resetn = 1'b1;
         end
      end
      in_ack = 1'b0;
      key = 4'hF;
      wait_cycles(20);
      check("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
